// File: rtl/instr_fetch_if.sv
// ---------------------------------------------------------------------------
// instr_fetch_if
//
// Purpose: bundles the signals between the instruction fetch unit, its
// 8-bit external memory port, the execute-stage redirect and the decoder
// handshake.
//
// Signals:
//   mem_req      fetch -> memory   byte read request
//   mem_addr     fetch -> memory   byte address, valid while mem_req=1
//   mem_rdata    memory -> fetch   read byte
//   mem_ack      memory -> fetch   byte transfer completes this cycle
//   redirect     execute -> fetch  one-cycle pulse, restart at redirect_pc
//   redirect_pc  execute -> fetch  new fetch PC
//   instr_valid  fetch -> decoder  instruction/instr_pc hold a complete word
//   instr_ready  decoder -> fetch  decoder accepts the word
//   instruction  fetch -> decoder  assembled word, byte 0 in [7:0]
//   instr_pc     fetch -> decoder  address of the presented word
//
// Modports: master = fetch unit side, slave = environment side.
// ---------------------------------------------------------------------------
interface instr_fetch_if;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic [7:0]  mem_rdata;
  logic        mem_ack;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instruction;
  logic [31:0] instr_pc;

  modport master (
    output mem_req, mem_addr, instr_valid, instruction, instr_pc,
    input  mem_rdata, mem_ack, redirect, redirect_pc, instr_ready
  );

  modport slave (
    input  mem_req, mem_addr, instr_valid, instruction, instr_pc,
    output mem_rdata, mem_ack, redirect, redirect_pc, instr_ready
  );
endinterface

// File: rtl/instr_fetch.sv
// ---------------------------------------------------------------------------
// instr_fetch
//
// Purpose: RV32I instruction fetch unit. Reads instruction bytes
// little-endian over an 8-bit memory port, assembles each 32-bit word and
// presents it with its PC to the decoder under a valid/ready handshake.
// A redirect pulse from execute discards all fetch state and restarts the
// stream at the (word-aligned) redirect target.
//
// Ports:
//   clk    in   single clock, all state changes on the rising edge
//   rst_n  in   synchronous active-low reset
//   bus    instr_fetch_if.master (memory port, redirect, decoder handshake)
//
// Parameter:
//   RESET_PC  fetch address after reset, bits [1:0] must be zero
//
// Configuration macro:
//   IFETCH_PREFETCH_EN  when defined, adds a one-word prefetch buffer that
//                       keeps fetching the next word while a word waits in
//                       HOLD (4 cycles/instr with zero-wait memory instead
//                       of 5).
// ---------------------------------------------------------------------------
module instr_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input logic          clk,
  input logic          rst_n,
  instr_fetch_if.master bus
);

  typedef enum logic {
    FETCH = 1'b0,
    HOLD  = 1'b1
  } state_t;

  state_t      state;
  logic [31:0] pc;
  logic [1:0]  byte_idx;
  logic [31:0] instr_q;
  logic [31:0] instr_pc_q;

  logic [31:0] pc_next;
  logic        valid_int;
  logic        req_int;
  logic        transfer;
  logic        byte_ack;

  // Only the word-aligned part of the redirect target is used.
  logic unused_redirect_bits;
  assign unused_redirect_bits = ^bus.redirect_pc[1:0];

  // pc + 4 wraps modulo 2^32 with no flag.
  assign pc_next   = pc + 32'd4;
  // Both outputs are forced low while reset is asserted, even before the
  // first reset edge has initialised the state register.
  assign valid_int = rst_n & (state == HOLD);
  assign transfer  = valid_int & bus.instr_ready;
  assign byte_ack  = req_int & bus.mem_ack;

`ifdef IFETCH_PREFETCH_EN
  // Prefetch buffer: holds the word at pc + 4 while the current word waits
  // in HOLD. Its PC is always pc + 4, so only data, fill index and the full
  // flag are stored.
  logic [31:0] buf_data;
  logic [1:0]  buf_idx;
  logic        buf_full;
  logic [31:0] buf_data_nx;
  logic [1:0]  buf_idx_nx;
  logic        buf_full_nx;

  // Buffer contents including a byte acked this cycle, so a decoder
  // transfer in the same cycle sees the freshest buffer state.
  always_comb begin
    buf_data_nx = buf_data;
    buf_idx_nx  = buf_idx;
    buf_full_nx = buf_full;
    if ((state == HOLD) && byte_ack) begin
      buf_data_nx[{buf_idx, 3'b000} +: 8] = bus.mem_rdata;
      buf_idx_nx = buf_idx + 2'd1;
      if (buf_idx == 2'd3) begin
        buf_full_nx = 1'b1;
      end
    end
  end

  // In HOLD the memory port keeps working on the next word until the buffer
  // is full.
  assign req_int      = rst_n & ((state == FETCH) | ~buf_full);
  assign bus.mem_addr = (state == HOLD) ? {pc_next[31:2], buf_idx}
                                        : {pc[31:2], byte_idx};
`else
  assign req_int      = rst_n & (state == FETCH);
  assign bus.mem_addr = {pc[31:2], byte_idx};
`endif

  assign bus.mem_req     = req_int;
  assign bus.instr_valid = valid_int;
  assign bus.instruction = instr_q;
  assign bus.instr_pc    = instr_pc_q;

  // Fetch FSM: reset beats redirect, redirect beats any byte ack or decoder
  // handshake in the same cycle. A same-cycle handshake is simply dropped
  // here because the decoder has already taken the word.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= FETCH;
      pc         <= RESET_PC;
      byte_idx   <= 2'd0;
      instr_q    <= 32'd0;
      instr_pc_q <= RESET_PC;
`ifdef IFETCH_PREFETCH_EN
      buf_data   <= 32'd0;
      buf_idx    <= 2'd0;
      buf_full   <= 1'b0;
`endif
    end else if (bus.redirect) begin
      state    <= FETCH;
      pc       <= {bus.redirect_pc[31:2], 2'b00};
      byte_idx <= 2'd0;
`ifdef IFETCH_PREFETCH_EN
      buf_idx  <= 2'd0;
      buf_full <= 1'b0;
`endif
    end else begin
      case (state)
        FETCH: begin
          if (byte_ack) begin
            instr_q[{byte_idx, 3'b000} +: 8] <= bus.mem_rdata;
            byte_idx <= byte_idx + 2'd1;
            if (byte_idx == 2'd3) begin
              instr_pc_q <= pc;
              state      <= HOLD;
            end
          end
        end
        HOLD: begin
`ifdef IFETCH_PREFETCH_EN
          if (transfer) begin
            pc       <= pc_next;
            instr_q  <= buf_data_nx;
            buf_idx  <= 2'd0;
            buf_full <= 1'b0;
            // A full buffer is promoted straight to the output so valid
            // stays high; a partial one continues in FETCH where the
            // already-captured bytes are kept.
            if (buf_full_nx) begin
              instr_pc_q <= pc_next;
            end else begin
              state    <= FETCH;
              byte_idx <= buf_idx_nx;
            end
          end else begin
            buf_data <= buf_data_nx;
            buf_idx  <= buf_idx_nx;
            buf_full <= buf_full_nx;
          end
`else
          if (transfer) begin
            pc    <= pc_next;
            state <= FETCH;
          end
`endif
        end
      endcase
    end
  end

endmodule

// File: tb/tb_instr_fetch.sv
// ---------------------------------------------------------------------------
// tb_instr_fetch
//
// Purpose: directed self-checking bench for instr_fetch. A behavioural
// memory returns bytes of a fixed pseudo-random image (word 0 holds
// 0x00500093) with a configurable number of random wait states per byte.
// Inputs are driven and outputs checked 1 time unit after the falling edge.
// ---------------------------------------------------------------------------
module tb_instr_fetch;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic clk;
  logic rst_n;
  instr_fetch_if bus ();

  int compared_cnt   = 0;
  int mismatched_cnt = 0;
  int wait_max       = 0;
  int wait_left      = 0;
  logic prev_xfer    = 1'b0;

  instr_fetch #(.RESET_PC(RESET_PC)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Free-running clock, rising edges at 5, 15, 25, ...
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Memory image: word 0 is addi x1,x0,5, everything else is derived from
  // the address so any misplaced byte shows up.
  function automatic logic [31:0] word_at(input logic [31:0] a);
    if (a == 32'h0) return 32'h0050_0093;
    return {a[15:0], ~a[15:0]} ^ 32'h1357_9BDF;
  endfunction

  function automatic logic [7:0] byte_at(input logic [31:0] a);
    logic [31:0] w;
    w = word_at({a[31:2], 2'b00});
    case (a[1:0])
      2'd0:    return w[7:0];
      2'd1:    return w[15:8];
      2'd2:    return w[23:16];
      default: return w[31:24];
    endcase
  endfunction

  assign bus.mem_rdata = byte_at(bus.mem_addr);

  // Memory ack model: after each completed byte a new wait count in
  // 0..wait_max is drawn; ack is withheld for that many cycles.
  always @(negedge clk) begin
    #3;
    if (prev_xfer) wait_left = int'($urandom_range(wait_max, 0));
    if (wait_left > 0) begin
      bus.mem_ack = 1'b0;
      wait_left   = wait_left - 1;
    end else begin
      bus.mem_ack = 1'b1;
    end
    prev_xfer = bus.mem_req && bus.mem_ack;
  end

  task automatic applyStimulus(input logic rst_val, input logic ready_val,
                               input logic redir_val, input logic [31:0] redir_pc);
    rst_n           = rst_val;
    bus.instr_ready = ready_val;
    bus.redirect    = redir_val;
    bus.redirect_pc = redir_pc;
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    compared_cnt++;
    assert (observed === expected) else begin
      mismatched_cnt++;
      $error("[TB] FAIL %s: observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic waitValid(input string tag, input int limit);
    int n;
    n = 0;
    while (bus.instr_valid !== 1'b1 && n < limit) begin
      tick();
      n++;
    end
    checkOutput(tag, {31'd0, bus.instr_valid}, 32'd1);
  endtask

  initial begin
    logic [31:0] exp_pc;
    logic [31:0] held_word;
    int          req_count;

    // Power-on reset with zero-wait memory.
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
    tick();
    checkOutput("rst_mem_req", {31'd0, bus.mem_req}, 32'd0);
    checkOutput("rst_valid", {31'd0, bus.instr_valid}, 32'd0);
    tick();
    checkOutput("rst_instr_pc", bus.instr_pc, RESET_PC);
    checkOutput("rst_instruction", bus.instruction, 32'd0);

    // Release: bytes from 0x0..0x3 on edges 1-4, valid from edge 4.
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
    checkOutput("first_req", {31'd0, bus.mem_req}, 32'd1);
    checkOutput("first_addr0", bus.mem_addr, 32'h0);
    tick();
    checkOutput("first_addr1", bus.mem_addr, 32'h1);
    tick();
    checkOutput("first_addr2", bus.mem_addr, 32'h2);
    tick();
    checkOutput("first_addr3", bus.mem_addr, 32'h3);
    checkOutput("first_not_valid", {31'd0, bus.instr_valid}, 32'd0);
    tick();
    checkOutput("first_valid", {31'd0, bus.instr_valid}, 32'd1);
    checkOutput("first_instruction", bus.instruction, 32'h0050_0093);
    checkOutput("first_instr_pc", bus.instr_pc, 32'h0);

    // Decoder stalls for 10 cycles: outputs must stay put.
    held_word = bus.instruction;
    req_count = 0;
    for (int i = 0; i < 10; i++) begin
`ifdef IFETCH_PREFETCH_EN
      if (bus.mem_req === 1'b1) req_count++;
`else
      checkOutput("hold_mem_req", {31'd0, bus.mem_req}, 32'd0);
`endif
      checkOutput("hold_valid", {31'd0, bus.instr_valid}, 32'd1);
      checkOutput("hold_instruction", bus.instruction, held_word);
      checkOutput("hold_instr_pc", bus.instr_pc, 32'h0);
      tick();
    end
`ifdef IFETCH_PREFETCH_EN
    checkOutput("hold_prefetch_acks", req_count, 32'd4);
`endif
    applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
    tick();
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
    waitValid("hold_next_valid", 20);
    checkOutput("hold_next_pc", bus.instr_pc, 32'h4);
    checkOutput("hold_next_word", bus.instruction, word_at(32'h4));

    // 16 sequential words with 0..3 random wait states per byte.
    wait_max = 3;
    applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
    exp_pc = 32'h4;
    for (int w = 0; w < 16; w++) begin
      waitValid("seq_valid", 40);
      checkOutput("seq_pc", bus.instr_pc, exp_pc);
      checkOutput("seq_word", bus.instruction, word_at(exp_pc));
      exp_pc = exp_pc + 32'd4;
      tick();
    end
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
    wait_max = 0;
    repeat (6) tick();

    // Redirect to 0x200, then redirect to 0x103 while byte 2 is being acked.
    applyStimulus(1'b1, 1'b0, 1'b1, 32'h0000_0200);
    tick();
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
    checkOutput("redir_a_addr0", bus.mem_addr, 32'h200);
    tick();
    checkOutput("redir_a_addr1", bus.mem_addr, 32'h201);
    tick();
    checkOutput("redir_a_addr2", bus.mem_addr, 32'h202);
    applyStimulus(1'b1, 1'b0, 1'b1, 32'h0000_0103);
    tick();
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
    checkOutput("redir_b_addr", bus.mem_addr, 32'h100);
    checkOutput("redir_b_not_valid", {31'd0, bus.instr_valid}, 32'd0);
    repeat (3) tick();
    checkOutput("redir_b_early", {31'd0, bus.instr_valid}, 32'd0);
    tick();
    checkOutput("redir_b_valid", {31'd0, bus.instr_valid}, 32'd1);
    checkOutput("redir_b_pc", bus.instr_pc, 32'h100);
    checkOutput("redir_b_word", bus.instruction, word_at(32'h100));

    // PC wrap from the last word of the address space.
    applyStimulus(1'b1, 1'b0, 1'b1, 32'hFFFF_FFFC);
    tick();
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
    repeat (4) tick();
    checkOutput("wrap_valid", {31'd0, bus.instr_valid}, 32'd1);
    checkOutput("wrap_pc", bus.instr_pc, 32'hFFFF_FFFC);
    checkOutput("wrap_word", bus.instruction, word_at(32'hFFFF_FFFC));
    applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
    tick();
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
    waitValid("wrap_next_valid", 20);
    checkOutput("wrap_next_pc", bus.instr_pc, 32'h0);
    checkOutput("wrap_next_word", bus.instruction, 32'h0050_0093);

    // Move on to the word at 0x4 and reset while it is held.
    applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
    tick();
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
    waitValid("prereset_valid", 20);
    checkOutput("prereset_pc", bus.instr_pc, 32'h4);
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
    checkOutput("midrst_mem_req", {31'd0, bus.mem_req}, 32'd0);
    checkOutput("midrst_valid", {31'd0, bus.instr_valid}, 32'd0);
    tick();
    checkOutput("midrst_mem_req2", {31'd0, bus.mem_req}, 32'd0);
    checkOutput("midrst_valid2", {31'd0, bus.instr_valid}, 32'd0);
    checkOutput("midrst_instr_pc", bus.instr_pc, RESET_PC);
    checkOutput("midrst_instruction", bus.instruction, 32'd0);
    tick();
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
    checkOutput("restart_req", {31'd0, bus.mem_req}, 32'd1);
    checkOutput("restart_addr", bus.mem_addr, RESET_PC);
    repeat (4) tick();
    checkOutput("restart_valid", {31'd0, bus.instr_valid}, 32'd1);
    checkOutput("restart_pc", bus.instr_pc, RESET_PC);
    checkOutput("restart_word", bus.instruction, 32'h0050_0093);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared_cnt, mismatched_cnt);
    $finish;
  end

endmodule
